// File: rtl/ones_counter_acc.sv
// Frame-based ones counter: popcounts each accepted word, accumulates the
// total and word count per frame, and presents a saturating result on a handshake.
module ones_counter_acc #(
    parameter int WIDTH  = 7,
    parameter int CNT_W  = 16,
    parameter int WRD_W  = 8,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] din,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] count,
    output logic [WRD_W-1:0] words,
    output logic             sat,
    output logic             above
);

    localparam int PW = $clog2(WIDTH + 1);
    localparam logic [63:0] THRESH_L = 64'(THRESH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PW-1:0] n;
        n = {PW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    logic [1:0]       state_r, state_nxt_s;
    logic             in_ready_r;
    logic [PW-1:0]    pop_r;
    logic             pv_r, pl_r;
    logic [CNT_W-1:0] acc_r, acc_nxt_s, base_s;
    logic [CNT_W:0]   sum_s;
    logic [WRD_W-1:0] wcnt_r, wcnt_nxt_s;
    logic             satf_r, satf_nxt_s;
    logic             accept_s, fin_s;
    logic             out_valid_r, sat_r, above_r;
    logic [CNT_W-1:0] count_r;
    logic [WRD_W-1:0] words_r;

    assign accept_s  = in_valid && in_ready_r;
    // The last word reaching stage 2 completes the frame.
    assign fin_s     = pv_r && pl_r;
    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign count     = count_r;
    assign words     = words_r;
    assign sat       = sat_r;
    assign above     = above_r;

    // Frame control next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    state_nxt_s = last ? ST_FLUSH : ST_ACCUM;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ACCUM: begin
                if (accept_s && last) begin
                    state_nxt_s = ST_FLUSH;
                end else begin
                    state_nxt_s = ST_ACCUM;
                end
            end
            ST_FLUSH: state_nxt_s = ST_DONE;
            ST_DONE: begin
                if (out_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Stage-2 saturating accumulate; an empty word counter marks the first word of a frame.
    always_comb begin
        base_s     = (wcnt_r == {WRD_W{1'b0}}) ? {CNT_W{1'b0}} : acc_r;
        sum_s      = {1'b0, base_s} + (CNT_W + 1)'(pop_r);
        acc_nxt_s  = acc_r;
        wcnt_nxt_s = wcnt_r;
        satf_nxt_s = satf_r;
        if (pv_r) begin
            if (sum_s[CNT_W]) begin
                acc_nxt_s  = {CNT_W{1'b1}};
                satf_nxt_s = 1'b1;
            end else begin
                acc_nxt_s = sum_s[CNT_W-1:0];
            end
            if (wcnt_r == {WRD_W{1'b1}}) begin
                wcnt_nxt_s = wcnt_r;
                satf_nxt_s = 1'b1;
            end else begin
                wcnt_nxt_s = wcnt_r + WRD_W'(1);
            end
        end else begin
            acc_nxt_s  = acc_r;
            wcnt_nxt_s = wcnt_r;
            satf_nxt_s = satf_r;
        end
    end

    // FSM state, input pipeline stage and frame accumulators.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b0;
            pop_r      <= {PW{1'b0}};
            pv_r       <= 1'b0;
            pl_r       <= 1'b0;
            acc_r      <= {CNT_W{1'b0}};
            wcnt_r     <= {WRD_W{1'b0}};
            satf_r     <= 1'b0;
        end else if (clear) begin
            state_r    <= ST_IDLE;
            in_ready_r <= 1'b1;
            pop_r      <= {PW{1'b0}};
            pv_r       <= 1'b0;
            pl_r       <= 1'b0;
            acc_r      <= {CNT_W{1'b0}};
            wcnt_r     <= {WRD_W{1'b0}};
            satf_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            in_ready_r <= (state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ACCUM);
            if (accept_s) begin
                pop_r <= popcount(din);
                pv_r  <= 1'b1;
                pl_r  <= last;
            end else begin
                pv_r  <= 1'b0;
            end
            if ((state_r == ST_DONE) && out_ready) begin
                acc_r  <= {CNT_W{1'b0}};
                wcnt_r <= {WRD_W{1'b0}};
                satf_r <= 1'b0;
            end else begin
                acc_r  <= acc_nxt_s;
                wcnt_r <= wcnt_nxt_s;
                satf_r <= satf_nxt_s;
            end
        end
    end

    // Result registers: loaded as the frame completes, held until the handshake.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_r <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
            words_r     <= {WRD_W{1'b0}};
            sat_r       <= 1'b0;
            above_r     <= 1'b0;
        end else if (clear || (out_valid_r && out_ready)) begin
            out_valid_r <= 1'b0;
            count_r     <= {CNT_W{1'b0}};
            words_r     <= {WRD_W{1'b0}};
            sat_r       <= 1'b0;
            above_r     <= 1'b0;
        end else if (fin_s) begin
            out_valid_r <= 1'b1;
            count_r     <= acc_nxt_s;
            words_r     <= wcnt_nxt_s;
            sat_r       <= satf_nxt_s;
            above_r     <= (64'(acc_nxt_s) >= THRESH_L);
        end else begin
            out_valid_r <= out_valid_r;
            count_r     <= count_r;
            words_r     <= words_r;
            sat_r       <= sat_r;
            above_r     <= above_r;
        end
    end

endmodule

// File: tb/tb_ones_counter_acc.sv
// Directed bench for ones_counter_acc: default instance plus a narrow-count
// instance sharing the same stimulus to exercise saturation.
module tb_ones_counter_acc;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       clear = 1'b0;
    logic       in_valid = 1'b0;
    logic       last = 1'b0;
    logic       out_ready = 1'b0;
    logic [6:0] din = 7'd0;

    logic        in_ready, out_valid, sat, above;
    logic [15:0] count;
    logic [7:0]  words;
    logic        in_ready2, out_valid2, sat2, above2;
    logic [3:0]  count2;
    logic [7:0]  words2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ones_counter_acc dut (
        .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .din(din), .last(last), .out_valid(out_valid), .out_ready(out_ready),
        .count(count), .words(words), .sat(sat), .above(above)
    );

    ones_counter_acc #(.WIDTH(7), .CNT_W(4)) dut_sat (
        .clk(clk), .rstn(rstn), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
        .din(din), .last(last), .out_valid(out_valid2), .out_ready(out_ready),
        .count(count2), .words(words2), .sat(sat2), .above(above2)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one word and return just after the edge that accepts it.
    task automatic send(input logic [6:0] w, input logic l);
        int n;
        din = w;
        last = l;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) check_val("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        last = 1'b0;
        din = 7'd0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #2;
        check_val("rst_in_ready", 64'(in_ready), 64'd0);
        check_val("rst_out_valid", 64'(out_valid), 64'd0);
        check_val("rst_count", 64'(count), 64'd0);
        #10 rstn = 1'b1;
        @(posedge clk);
        #1;
        check_val("ready_after_rst", 64'(in_ready), 64'd1);

        // Three-word frame 1+2+4 ones.
        send(7'b0000001, 1'b0);
        check_val("b2b_ready1", 64'(in_ready), 64'd1);
        send(7'b0000011, 1'b0);
        check_val("b2b_ready2", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        send(7'b0011110, 1'b1);
        check_val("f1_valid_e", 64'(out_valid), 64'd0);
        check_val("f1_ready_flush", 64'(in_ready), 64'd0);
        check_val("f1_count_flush", 64'(count), 64'd0);
        @(posedge clk);
        #1;
        check_val("f1_valid", 64'(out_valid), 64'd1);
        check_val("f1_count", 64'(count), 64'd7);
        check_val("f1_words", 64'(words), 64'd3);
        check_val("f1_sat", 64'(sat), 64'd0);
        check_val("f1_above", 64'(above), 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val("f1_valid_after", 64'(out_valid), 64'd0);
        check_val("f1_count_after", 64'(count), 64'd0);
        check_val("f1_words_after", 64'(words), 64'd0);
        check_val("f1_ready_after", 64'(in_ready), 64'd1);

        // Single-word frame, then stall the result for 5 cycles.
        send(7'b0000001, 1'b1);
        check_val("f2_ready_flush", 64'(in_ready), 64'd0);
        @(posedge clk);
        #1;
        check_val("f2_valid", 64'(out_valid), 64'd1);
        check_val("f2_count", 64'(count), 64'd1);
        check_val("f2_words", 64'(words), 64'd1);
        check_val("f2_above", 64'(above), 64'd0);
        in_valid = 1'b1;
        din = 7'h7f;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check_val("stall_valid", 64'(out_valid), 64'd1);
            check_val("stall_count", 64'(count), 64'd1);
            check_val("stall_words", 64'(words), 64'd1);
            check_val("stall_ready", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        din = 7'd0;
        handshake();
        check_val("f2_valid_after", 64'(out_valid), 64'd0);
        check_val("f2_ready_after", 64'(in_ready), 64'd1);

        // Three all-ones words: 21 in the wide instance, clamps at 15 in the narrow one.
        send(7'h7f, 1'b0);
        send(7'h7f, 1'b0);
        send(7'h7f, 1'b1);
        @(posedge clk);
        #1;
        check_val("f3_count", 64'(count), 64'd21);
        check_val("f3_sat", 64'(sat), 64'd0);
        check_val("f3_words", 64'(words), 64'd3);
        check_val("f3_count_narrow", 64'(count2), 64'd15);
        check_val("f3_sat_narrow", 64'(sat2), 64'd1);
        check_val("f3_words_narrow", 64'(words2), 64'd3);
        handshake();

        // Clear mid-frame, then a fresh single-word frame.
        send(7'h05, 1'b0);
        send(7'h0f, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        check_val("clr_ready", 64'(in_ready), 64'd1);
        check_val("clr_valid", 64'(out_valid), 64'd0);
        send(7'b1000000, 1'b1);
        @(posedge clk);
        #1;
        check_val("f4_count", 64'(count), 64'd1);
        check_val("f4_words", 64'(words), 64'd1);
        handshake();

        // Reset between edges while a result is pending.
        send(7'h7f, 1'b0);
        send(7'h7f, 1'b1);
        @(posedge clk);
        #1;
        check_val("f5_count", 64'(count), 64'd14);
        #2 rstn = 1'b0;
        #1;
        check_val("arst_valid", 64'(out_valid), 64'd0);
        check_val("arst_count", 64'(count), 64'd0);
        check_val("arst_words", 64'(words), 64'd0);
        check_val("arst_above", 64'(above), 64'd0);
        check_val("arst_ready", 64'(in_ready), 64'd0);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        check_val("arst_ready_after", 64'(in_ready), 64'd1);

        // Reset mid-frame; the next frame must not see the earlier word.
        send(7'h7f, 1'b0);
        #2 rstn = 1'b0;
        #1 rstn = 1'b1;
        send(7'b0000011, 1'b1);
        @(posedge clk);
        #1;
        check_val("f6_count", 64'(count), 64'd2);
        check_val("f6_words", 64'(words), 64'd1);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ones_counter_acc.md
ONES_COUNTER_ACC -- requirements
Module: ones_counter_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 7, bits per input word (1..64).
REQ-002 SHALL have parameter CNT_W, default 16, width of ones total (>= clog2(WIDTH+1)).
REQ-003 SHALL have parameter WRD_W, default 8, width of word counter.
REQ-004 SHALL have parameter THRESH, default 4, ones threshold for the above flag.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  single clock, rising edge
- rstn  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous frame abort
- in_valid  in  1  din/last valid
- in_ready  out  1  block accepts word
- din  in  WIDTH  input word
- last  in  1  word is final word of frame
- out_valid  out  1  frame result valid
- out_ready  in  1  consumer accepts result
- count  out  CNT_W  total ones in frame
- words  out  WRD_W  words in frame
- sat  out  1  count or words saturated
- above  out  1  count >= THRESH

Function
REQ-006 SHALL accept a word on a rising edge where in_valid and in_ready are both 1 (accept edge E).
REQ-007 SHALL use FSM states IDLE, ACCUM, FLUSH, DONE.
REQ-008 in_ready SHALL be 1 in IDLE and ACCUM, 0 in FLUSH and DONE.
REQ-009 Stage 1: at E, pop_q <= number of 1 bits in din (0..WIDTH), pv_q <= 1, pl_q <= last; otherwise pv_q <= 0.
REQ-010 Stage 2: on the edge after E, acc <= acc + pop_q and wcnt <= wcnt + 1, where the first word of a frame loads acc <= pop_q and wcnt <= 1.
REQ-011 acc SHALL saturate at 2^CNT_W-1 and wcnt at 2^WRD_W-1; either saturation sets sticky frame flag satf.
REQ-012 Transitions: IDLE->ACCUM on accept without last; IDLE or ACCUM -> FLUSH on accept with last; FLUSH->DONE unconditionally; DONE->IDLE on out_valid and out_ready.
REQ-013 out_valid SHALL be 1 exactly in DONE; latency from last-word accept edge E to out_valid high is 2 edges (visible after E+1).
REQ-014 In DONE, count=acc, words=wcnt, sat=satf, above=(acc>=THRESH); all SHALL hold stable until the handshake.
REQ-015 Outside DONE, count, words, sat, above SHALL be 0.
REQ-016 Back-to-back words SHALL be accepted every cycle in ACCUM with no bubble.
REQ-017 After DONE->IDLE, in_ready SHALL be 1 in the following cycle; the next frame starts from acc=0, wcnt=0, satf=0.
REQ-018 clear=1 SHALL, at the next edge, force state IDLE and acc, wcnt, satf, pv_q to 0; no word is accepted on that edge; clear has priority over all other events, including a pending result in DONE (discarded).
REQ-019 A single-word frame (last on first word) SHALL produce words=1 and count=popcount of that word.
REQ-020 out_ready while not in DONE SHALL be ignored.

Reset
REQ-021 rstn=0 SHALL immediately (asynchronously) force state IDLE; acc, wcnt, satf, pop_q, pv_q, pl_q = 0; out_valid=0, count=0, words=0, sat=0, above=0.
REQ-022 While rstn=0, in_ready SHALL be 0; it SHALL be 1 from the first edge after rstn deasserts.
REQ-023 Reset asserted mid-frame or in DONE SHALL discard all partial or pending results.

Verification
REQ-024 Defaults; frame words 0000001, 0000011, 0011110 (last on third), out_ready=1 -> out_valid 2 edges after third accept, count=7, words=3, sat=0, above=1.
REQ-025 Single word 0000001 with last -> count=1, words=1, above=0; in_ready low for FLUSH and DONE cycles.
REQ-026 Result pending with out_ready=0 for 5 cycles -> out_valid, count, words stable; in_ready=0; no input accepted.
REQ-027 CNT_W=4, WIDTH=7: three words 1111111 -> count=15, sat=1.
REQ-028 clear asserted in ACCUM after two words, then new frame 1000000 with last -> count=1, words=1.
REQ-029 rstn pulsed low mid-frame between clock edges -> outputs 0 immediately; subsequent frame result unaffected by pre-reset words.
